if_fetch_stage: RTL and testbench

Fetch stage and IF/ID pipeline register for the RV32I core. Owns the PC and issues one instruction-memory request at a time over a request/response interface. Places fetched instructions into the IF/ID register. Obeys the hazard unit's stall and flush controls and the EX-stage redirect (taken branch or jump), discarding any in-flight fetch that has become stale.

---
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_if_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the RV32I core.
// Keeps a single instruction-memory request in flight and drops fetches made stale by a redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        if_id_write,
   input  logic        if_id_flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_buf;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_plus4;
   logic        accept;
   logic        load;
   logic [31:0] load_instr;
   logic        unused_redirect_lsbs;

   assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign pc_plus4             = pc + 32'd4;
   assign accept               = pc_write & if_id_write & ~if_id_flush & ~redirect_valid;

   assign imem_req  = (state == StReq) & ~redirect_valid & ~rst;
   assign imem_addr = pc;

   // An instruction is handed to IF/ID either straight from memory or from the hold buffer.
   always_comb begin
      load       = 1'b0;
      load_instr = hold_buf;
      unique case (state)
         StWait: begin
            if (imem_rvalid && accept) begin
               load       = 1'b1;
               load_instr = imem_rdata;
            end
         end
         StHold: begin
            if (accept) begin
               load = 1'b1;
            end
         end
         default: begin
            load = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StReq;
         pc          <= RESET_PC;
         hold_buf    <= 32'h0;
         if_id_pc    <= 32'h0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else begin
         if (redirect_valid) begin
            pc <= redirect_tgt;
         end else if (load) begin
            pc <= pc_plus4;
         end

         case (state)
            StReq: begin
               if (!redirect_valid) begin
                  state <= StWait;
               end
            end
            StWait: begin
               if (redirect_valid) begin
                  state <= imem_rvalid ? StReq : StDrop;
               end else if (imem_rvalid) begin
                  if (load) begin
                     state <= StReq;
                  end else begin
                     hold_buf <= imem_rdata;
                     state    <= StHold;
                  end
               end
            end
            StHold: begin
               if (redirect_valid || load) begin
                  state <= StReq;
               end
            end
            StDrop: begin
               // The stale response clears the outstanding request even if another redirect
               // lands in the same cycle; staying here would wait for a response that never comes.
               if (imem_rvalid) begin
                  state <= StReq;
               end
            end
            default: begin
               state <= StReq;
            end
         endcase

         if (if_id_flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (if_id_write) begin
            if (load) begin
               if_id_pc    <= pc;
               if_id_instr <= load_instr;
               if_id_valid <= 1'b1;
            end else begin
               if_id_instr <= NOP_INSTR;
               if_id_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: request and IF/ID scoreboards fed by the stimulus,
// drained by a negedge monitor, plus a behavioural instruction memory with variable latency.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'hDEAD_BEEF;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   int n_cmp = 0;
   int n_bad = 0;
   int mem_lat;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   logic [31:0] exp_req[$];
   ifid_t       exp_ifid[$];

   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .if_id_valid    (if_id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0008) return 32'h0050_0093;
      return 32'h5A00_0000 ^ a;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_req(input logic [31:0] a);
      exp_req.push_back(a);
   endtask

   task automatic push_ifid(input logic [31:0] a, input logic [31:0] instr);
      ifid_t e;
      e.pc    = a;
      e.instr = instr;
      exp_ifid.push_back(e);
   endtask

   // Memory model: one response, mem_lat cycles after each request; cleared by reset.
   logic        pend = 1'b0;
   int          dly  = 0;
   logic [31:0] paddr;

   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else if (imem_req) begin
         pend  = 1'b1;
         dly   = mem_lat;
         paddr = imem_addr;
      end
   end

   always @(posedge clk) begin
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (pend) begin
         dly--;
         if (dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pend        = 1'b0;
         end
      end
   end

   // Monitor: IF/ID contents depend on the controls seen in the previous cycle.
   logic        prev_rst = 1'b1;
   logic        prev_wr  = 1'b1;
   logic        prev_fl  = 1'b0;
   logic [31:0] s_pc;
   logic [31:0] s_instr;
   logic        s_valid;

   always @(negedge clk) begin
      ifid_t e;
      logic [31:0] a;
      if (!rst && imem_req) begin
         if (exp_req.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_req: got %08h, expected no request (t=%0t)", imem_addr, $time);
         end else begin
            a = exp_req.pop_front();
            check("req_addr", imem_addr, a);
         end
      end
      if (!prev_rst) begin
         if (prev_fl) begin
            check("flush_valid", {31'b0, if_id_valid}, 32'h0);
            check("flush_instr", if_id_instr, NOP);
         end else if (!prev_wr) begin
            check("hold_pc", if_id_pc, s_pc);
            check("hold_instr", if_id_instr, s_instr);
            check("hold_valid", {31'b0, if_id_valid}, {31'b0, s_valid});
         end else if (if_id_valid) begin
            if (exp_ifid.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ifid: got pc %08h instr %08h, expected none (t=%0t)",
                        if_id_pc, if_id_instr, $time);
            end else begin
               e = exp_ifid.pop_front();
               check("ifid_pc", if_id_pc, e.pc);
               check("ifid_instr", if_id_instr, e.instr);
            end
         end
      end
      prev_rst = rst;
      prev_wr  = if_id_write;
      prev_fl  = if_id_flush;
      s_pc     = if_id_pc;
      s_instr  = if_id_instr;
      s_valid  = if_id_valid;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b1;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_id_flush    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mem_lat        = 1;
      cyc();
      cyc();
      mid();
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_instr", if_id_instr, NOP);
      check("rst_pc", if_id_pc, 32'h0);

      // Straight line at L=1, then a stall while the fetch of 0x8 is in flight.
      push_req(32'h0);
      push_req(32'h4);
      push_req(32'h8);
      push_req(32'hC);
      push_ifid(32'h0, 32'h5A00_0000);
      push_ifid(32'h4, 32'h5A00_0004);
      push_ifid(32'h8, 32'h0050_0093);
      push_ifid(32'hC, 32'h5A00_000C);
      cyc(); rst = 1'b0;                                   // c0
      mid(); check("c0_valid", {31'b0, if_id_valid}, 32'h0);
      cyc(); mid(); check("c1_valid", {31'b0, if_id_valid}, 32'h0);
      cyc(); mid(); check("c2_valid", {31'b0, if_id_valid}, 32'h1);
      cyc(); mid(); check("c3_valid", {31'b0, if_id_valid}, 32'h0);
      cyc(); pc_write = 1'b0; if_id_write = 1'b0;          // c4
      mid(); check("c4_valid", {31'b0, if_id_valid}, 32'h1);
      cyc(); mid(); check("c5_req", {31'b0, imem_req}, 32'h0);
      cyc();                                               // c6
      cyc(); pc_write = 1'b1; if_id_write = 1'b1;          // c7
      cyc();                                               // c8
      mid(); check("release_pc", if_id_pc, 32'h8);
      check("release_instr", if_id_instr, 32'h0050_0093);

      // Redirect while waiting, L=3.
      cyc(); mem_lat = 3;                                  // c9
      push_req(32'h10);
      push_req(32'h100);
      push_ifid(32'h100, 32'h5A00_0100);
      cyc();                                               // c10
      cyc(); redirect_valid = 1'b1; redirect_pc = 32'h103; // c11
      mid(); check("redir_noreq", {31'b0, imem_req}, 32'h0);
      cyc(); redirect_valid = 1'b0;                        // c12
      cyc(); mid(); check("drop_noreq", {31'b0, imem_req}, 32'h0);
      cyc(); mid(); check("redir_addr", imem_addr, 32'h100);
      cyc(); cyc(); cyc();                                 // c15..c17

      // Redirect + stall + flush together, target at the top of memory.
      cyc();                                               // c18
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      pc_write = 1'b0; if_id_flush = 1'b1; mem_lat = 1;
      push_req(32'hFFFF_FFFC);
      push_req(32'h0);
      push_req(32'h4);
      push_ifid(32'hFFFF_FFFC, 32'hA5FF_FFFC);
      push_ifid(32'h0, 32'h5A00_0000);
      mid(); check("combo_noreq", {31'b0, imem_req}, 32'h0);
      cyc(); redirect_valid = 1'b0; pc_write = 1'b1; if_id_flush = 1'b0;   // c19
      mid(); check("combo_valid", {31'b0, if_id_valid}, 32'h0);
      check("combo_instr", if_id_instr, NOP);
      check("combo_pc_kept", if_id_pc, 32'h100);
      check("combo_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(); cyc();                                        // c20, c21
      mid(); check("wrap_addr", imem_addr, 32'h0);
      cyc();                                               // c22

      // Stall into HOLD, then reset.
      cyc(); pc_write = 1'b0; if_id_write = 1'b0;          // c23
      cyc();                                               // c24
      cyc(); rst = 1'b1;                                   // c25
      mid(); check("hold_rst_req", {31'b0, imem_req}, 32'h0);
      cyc();                                               // c26
      mid(); check("post_rst_addr", imem_addr, 32'h0);
      check("post_rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("post_rst_instr", if_id_instr, NOP);
      check("post_rst_req", {31'b0, imem_req}, 32'h0);
      cyc(); rst = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;   // c27
      push_req(32'h0);
      push_req(32'h4);
      push_req(32'h8);
      push_ifid(32'h0, 32'h5A00_0000);
      push_ifid(32'h4, 32'h5A00_0004);
      mid(); check("first_req", {31'b0, imem_req}, 32'h1);
      check("first_addr", imem_addr, 32'h0);
      cyc(); cyc(); cyc();                                 // c28..c30
      cyc(); pc_write = 1'b0; if_id_write = 1'b0;          // c31
      cyc(); cyc(); cyc(); cyc();                          // c32..c35
      mid();
      check("req_left", exp_req.size(), 32'h0);
      check("ifid_left", exp_ifid.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
